mux_2x1: RTL and testbench
==========================

Name: mux_2x1

Overview:
Parameterised 2:1 data multiplexer with a registered output stage. It selects one of two WIDTH-bit operands under a single select bit. It is a generic datapath steering element placed wherever two buses converge onto one consumer. The output register isolates downstream timing from the select and data paths.

Parameters:
WIDTH, 8, bit width of both data inputs and the data output (legal range 1 or more)
OUT_REG, 1, 1 = registered output (1-cycle latency); 0 = purely combinational output, with clk and rst_n unused for the data path

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous reset, active low
in0  input  WIDTH  data operand selected when sel = 0
in1  input  WIDTH  data operand selected when sel = 1
sel  input  1  select: 0 -> in0, 1 -> in1
out  output  WIDTH  selected data
sel_q  output  1  select value that produced the current out (registered copy of sel when OUT_REG = 1; equals sel when OUT_REG = 0)

Interface notes:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- All inputs are synchronous to clk.

Behaviour:
- Selection function: mux_d = (sel == 1) ? in1 : in0, applied bitwise over WIDTH bits.
- No arithmetic, truncation or sign handling; data passes unmodified.
- OUT_REG = 1:
  - On each rising clk edge: out <= mux_d and sel_q <= sel.
  - Latency is exactly 1 clock. Inputs stable before edge N appear on out after edge N.
  - Throughput is one new selection per cycle.
  - rst_n low: out = 0 and sel_q = 0 immediately, without waiting for a clock edge. Both hold while rst_n is low.
  - Release of rst_n is synchronous in effect. The first load occurs on the first rising edge after rst_n goes high.
  - Reset asserted mid-operation: out clears to 0 immediately, and any pending value is discarded.
- OUT_REG = 0:
  - out = mux_d and sel_q = sel, continuously and combinationally.
  - Reset has no effect on the outputs.
- Simultaneous change of sel and data in the same cycle: the value sampled at the edge is the new sel applied to the new data. There is no glitch state on out when registered.
- Unknown (X) sel is not required to be handled. The bench drives sel only with 0 or 1.
- The select has no memory beyond sel_q. No enable, no handshake, and no back-pressure.

Test Plan:
- Reset: rst_n = 0 with in0 = 8'hA5, in1 = 8'h3C, sel = 1, clock running -> out = 8'h00 and sel_q = 0 throughout. After release, out = 8'h3C and sel_q = 1 one edge later.
- Select in0: in0 = 8'h24, in1 = 8'h81, sel = 0, one edge -> out = 8'h24, sel_q = 0.
- Select in1: hold data, set sel = 1, one edge -> out = 8'h81, sel_q = 1. out must still read 8'h24 before that edge, confirming 1-cycle latency.
- Random regression: 10 iterations of random in0/in1 (modulo 256). For each, set sel = 0 then sel = 1, sampling 1 ns after the following edge -> out equals in0 then in1 respectively, with zero mismatches counted.
- Async reset mid-stream: out = 8'hFF (in1 = 8'hFF, sel = 1), pulse rst_n low between edges -> out = 8'h00 before the next edge. out returns to 8'hFF on the first edge after release.
- Boundary data: in0 = 8'h00 and in1 = 8'hFF, toggling sel every cycle -> out alternates 8'h00 / 8'hFF, lagging sel by one cycle.

Source files
------------

// File: rtl/mux_2x1.sv
// Two-input WIDTH-bit steering mux with an optional registered output stage.
// sel_q reports the select value that produced the data currently on out.
module mux_2x1 #(
  parameter int unsigned WIDTH   = 8,
  parameter bit          OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             sel_q
);

  logic [WIDTH-1:0] mux_d;

  // NOTE: every path assigns mux_d, so no storage is inferred here.
  always_comb begin
    mux_d = sel ? in1 : in0;
  end

  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] out_q;
    logic             sel_r_q;

    // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q   <= '0;
        sel_r_q <= 1'b0;
      end else begin
        out_q   <= mux_d;
        sel_r_q <= sel;
      end
    end

    assign out   = out_q;
    assign sel_q = sel_r_q;
  end else begin : g_comb
    // Clock and reset play no part in the purely combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign out   = mux_d;
    assign sel_q = sel;
  end

endmodule

// File: tb/tb_mux_2x1.sv
// Scoreboard bench for mux_2x1: registered instance checked by a queue-driven
// monitor, with a combinational instance checked alongside on the same inputs.
module tb_mux_2x1;

  typedef struct packed {
    logic [7:0] out;
    logic       sel;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       sel;
  logic [7:0] out_r;
  logic       sel_q_r;
  logic [7:0] out_c;
  logic       sel_q_c;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  mux_2x1 #(.WIDTH(8), .OUT_REG(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in0  (in0),
    .in1  (in1),
    .sel  (sel),
    .out  (out_r),
    .sel_q(sel_q_r)
  );

  mux_2x1 #(.WIDTH(8), .OUT_REG(1'b0)) dut_c (
    .clk  (clk),
    .rst_n(rst_n),
    .in0  (in0),
    .in1  (in1),
    .sel  (sel),
    .out  (out_c),
    .sel_q(sel_q_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the registered output is compared 1 ns after each edge that has
  // an expectation queued for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("reg_out", out_r, e.out);
        check("reg_sel_q", {7'd0, sel_q_r}, {7'd0, e.sel});
      end
    end
  end

  // Drive one vector between edges; sel_val is the hand-computed selection.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] sel_val, input logic rst_val);
    exp_t e;
    @(negedge clk);
    in0   = a;
    in1   = b;
    sel   = s;
    rst_n = rst_val;
    #1;
    check("comb_out", out_c, sel_val);
    check("comb_sel_q", {7'd0, sel_q_c}, {7'd0, s});
    e.out = rst_val ? sel_val : 8'h00;
    e.sel = rst_val ? s : 1'b0;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    bit         drained;

    rst_n = 1'b1;
    in0   = 8'hA5;
    in1   = 8'h3C;
    sel   = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_async_out", out_r, 8'h00);
    check("reset_async_sel_q", {7'd0, sel_q_r}, 8'h00);

    // Reset held with clock running, then release.
    for (int i = 0; i < 3; i++) step(8'hA5, 8'h3C, 1'b1, 8'h3C, 1'b0);
    step(8'hA5, 8'h3C, 1'b1, 8'h3C, 1'b1);

    // Select in0, then in1 with the 1-cycle latency observed before the edge.
    step(8'h24, 8'h81, 1'b0, 8'h24, 1'b1);
    step(8'h24, 8'h81, 1'b1, 8'h81, 1'b1);
    check("latency_hold", out_r, 8'h24);

    // Random regression.
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      step(a, b, 1'b0, a, 1'b1);
      step(a, b, 1'b1, b, 1'b1);
    end

    // Asynchronous reset pulse between edges.
    step(8'h00, 8'hFF, 1'b1, 8'hFF, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out", out_r, 8'h00);
    check("midreset_sel_q", {7'd0, sel_q_r}, 8'h00);
    check("midreset_comb_out", out_c, 8'hFF);
    #1 rst_n = 1'b1;
    step(8'h00, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Boundary data with sel toggling every cycle.
    for (int i = 0; i < 8; i++) begin
      s = (i % 2 == 1);
      step(8'h00, 8'hFF, s, s ? 8'hFF : 8'h00, 1'b1);
    end

    drained = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
